// File: rtl/cs_pkg.sv
// Shared constants and helpers for the CS result path (Y width, FIFO sizing,
// warm-up length, drop-counter width).
package cs_pkg;

  localparam int CS_Y_W        = 10;
  localparam int CS_FIFO_DEPTH = 8;
  localparam int CS_WARMUP     = 8;
  localparam int CS_DROP_CNT_W = 8;

  localparam logic [CS_DROP_CNT_W-1:0] CS_DROP_MAX = 8'd255;

  // Per-cycle events of the result FIFO, grouped for easy observation.
  typedef struct packed {
    logic pop;
    logic push;
    logic drop;
    logic discard;
  } cs_fifo_ev_t;

  function automatic logic [CS_DROP_CNT_W-1:0] cs_sat_inc(
    input logic [CS_DROP_CNT_W-1:0] v
  );
    return (v == CS_DROP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cs_fifo_ram.sv
// DEPTH x WIDTH register file for the result FIFO: one synchronous write
// port, one asynchronous read port, storage is not reset.
module cs_fifo_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cs_result_fifo.sv
// Result FIFO behind the CS block: discards warm-up samples, buffers Y results
// and tracks drops. Define CS_PEAK_TRACK_EN to add the peak_y output.
module cs_result_fifo
  import cs_pkg::*;
#(
  parameter int WIDTH  = CS_Y_W,
  parameter int DEPTH  = CS_FIFO_DEPTH,  // power of two, >= 2
  parameter int WARMUP = CS_WARMUP,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         y_in,
  input  logic                     y_in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
  output logic [CW-1:0]            count,
  output logic                     overflow,
  output logic [CS_DROP_CNT_W-1:0] drop_cnt,
`ifdef CS_PEAK_TRACK_EN
  output logic [WIDTH-1:0]         peak_y,
`endif
  input  logic                     clr_ovf
);

  localparam int WARM_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARMUP);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);

  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [WARM_W-1:0]        warm_cnt_q, warm_cnt_d;
  logic                     overflow_q, overflow_d;
  logic [CS_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                     warm_done;
  logic [WIDTH-1:0]         rd_data;
  cs_fifo_ev_t              ev;

  assign warm_done = (warm_cnt_q == WARM_END);
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign out_valid = !empty;

  // Output handshake: a result transfers on any rising edge where
  // out_valid && out_ready; out_data holds steady while out_valid && !out_ready.
  // y_in has no backpressure: a valid sample that cannot be stored is dropped.
  always_comb begin
    ev         = '0;
    ev.pop     = out_valid && out_ready;
    ev.discard = y_in_valid && !warm_done;
    ev.push    = y_in_valid && warm_done && (!full || ev.pop);
    ev.drop    = y_in_valid && warm_done && full && !ev.pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    warm_cnt_d = warm_cnt_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (ev.push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ev.pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({ev.push, ev.pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (ev.discard) warm_cnt_d = warm_cnt_q + 1'b1;

    // A drop in the same cycle as clr_ovf restarts the tally at one.
    if (ev.drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = clr_ovf ? CS_DROP_CNT_W'(1) : cs_sat_inc(drop_cnt_q);
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      warm_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      warm_cnt_q <= warm_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cs_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ev.push),
    .waddr (wr_ptr_q),
    .wdata (y_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign out_data = empty ? '0 : rd_data;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

`ifdef CS_PEAK_TRACK_EN
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0] peak_base;

  // clr_ovf zeroes the running peak before a coincident push is folded in.
  always_comb begin
    peak_base = clr_ovf ? '0 : peak_q;
    peak_d    = peak_base;
    if (ev.push && (y_in > peak_base)) peak_d = y_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_y = peak_q;
`endif

endmodule

// File: tb/tb_cs_result_fifo.sv
// Self-checking bench for cs_result_fifo: directed and random steps compared
// against a queue-based reference model of the result FIFO.
module tb_cs_result_fifo;

  localparam int W  = 10;
  localparam int D  = 8;
  localparam int WU = 8;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] y_in       = '0;
  logic         y_in_valid = 1'b0;
  logic         out_ready  = 1'b0;
  logic         clr_ovf    = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         full;
  logic         empty;
  logic [3:0]   count;
  logic         overflow;
  logic [7:0]   drop_cnt;
`ifdef CS_PEAK_TRACK_EN
  logic [W-1:0] peak_y;
`endif

  cs_result_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .y_in_valid (y_in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
`ifdef CS_PEAK_TRACK_EN
    .peak_y     (peak_y),
`endif
    .clr_ovf    (clr_ovf)
  );

  // reference model state
  logic [W-1:0] exp_q[$];
  int           m_warm;
  bit           m_ovf;
  int           m_drop;
  int           m_peak;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_warm = 0;
    m_ovf  = 0;
    m_drop = 0;
    m_peak = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_data;
    exp_data = (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    check({tag, ".out_data"},  32'(out_data),  exp_data);
    check({tag, ".count"},     32'(count),     32'(exp_q.size()));
    check({tag, ".full"},      32'(full),      32'(exp_q.size() == D));
    check({tag, ".empty"},     32'(empty),     32'(exp_q.size() == 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drop));
`ifdef CS_PEAK_TRACK_EN
    check({tag, ".peak_y"},    32'(peak_y),    32'(m_peak));
`endif
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input string tag, input bit v, input int y, input bit rdy, input bit clr);
    bit pop, wd, fl, push, drop;
    y_in       = W'(y);
    y_in_valid = v;
    out_ready  = rdy;
    clr_ovf    = clr;
    pop  = rdy && (exp_q.size() > 0);
    wd   = (m_warm == WU);
    fl   = (exp_q.size() == D);
    push = v && wd && (!fl || pop);
    drop = v && wd && fl && !pop;
    if (v && !wd) m_warm++;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(W'(y));
    if (drop) begin
      m_ovf  = 1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    if (push) begin
      if (clr) m_peak = 0;
      if ((y % 1024) > m_peak) m_peak = y % 1024;
    end else if (clr) begin
      m_peak = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step("rand", $urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // warm-up discards the first WU valid samples
    for (int i = 1; i <= 12; i++) step("warmup", 1'b1, i, 1'b0, 1'b0);
    check("warmup.count4", 32'(count), 32'd4);
    check("warmup.head9", 32'(out_data), 32'd9);
    check("warmup.no_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step("drain_w", 1'b0, 0, 1'b1, 1'b0);

    // fill past capacity, then hold without ready
    for (int i = 100; i <= 109; i++) step("fill", 1'b1, i, 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'd1);
    check("fill.drop2", 32'(drop_cnt), 32'd2);
    check("fill.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 0, 1'b0, 1'b0);

    // simultaneous push/pop at full
    step("fullpp", 1'b1, 500, 1'b1, 1'b0);
    check("fullpp.count8", 32'(count), 32'd8);
    check("fullpp.drop2", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 9; i++) step("drain", 1'b0, 0, 1'b1, 1'b0);

    // saturate the drop counter
    for (int i = 0; i < D; i++) step("refill", 1'b1, int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step("sat", 1'b1, int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    check("sat.255", 32'(drop_cnt), 32'd255);
    step("clr", 1'b0, 0, 1'b0, 1'b1);
    check("clr.ovf0", 32'(overflow), 32'd0);
    check("clr.cnt0", 32'(drop_cnt), 32'd0);
    step("clrdrop", 1'b1, 77, 1'b0, 1'b1);
    check("clrdrop.ovf1", 32'(overflow), 32'd1);
    check("clrdrop.cnt1", 32'(drop_cnt), 32'd1);

    // peak tracking
    for (int i = 0; i < D; i++) step("drain_p", 1'b0, 0, 1'b1, 1'b0);
    step("pclr", 1'b0, 0, 1'b0, 1'b1);
    step("peak", 1'b1, 300, 1'b0, 1'b0);
    step("peak", 1'b1, 1023, 1'b0, 1'b0);
    step("peak", 1'b1, 7, 1'b0, 1'b0);
`ifdef CS_PEAK_TRACK_EN
    check("peak.1023", 32'(peak_y), 32'd1023);
`endif
    step("peak_clr", 1'b0, 0, 1'b0, 1'b1);
`ifdef CS_PEAK_TRACK_EN
    check("peak.clr0", 32'(peak_y), 32'd0);
`endif

    random_steps(400);

    // mid-operation asynchronous reset with five entries held
    for (int i = 0; i < D + 2; i++) step("drain_r", 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("load5", 1'b1, 200 + i, 1'b0, 1'b0);
    check("load5.count", 32'(count), 32'd5);
    y_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    check("midreset.count0", 32'(count), 32'd0);
    check("midreset.data0", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) step("rewarm", 1'b1, i, 1'b0, 1'b0);
    check("rewarm.count4", 32'(count), 32'd4);
    check("rewarm.head9", 32'(out_data), 32'd9);

    random_steps(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
